// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Byte-stream program loader; assembles little-endian words into
//               BRAM and releases the core after a trailing XOR checksum match.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10,
    parameter int NCOL      = 4,
    parameter int BASE_WORD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid_i,
    input  logic [7:0]           s_data_i,
    output logic                 s_ready_o,
    output logic [NCOL-1:0]      mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [NCOL*8-1:0]    mem_wdata_o,
    output logic                 core_reset_o,
    output logic                 load_done_o,
    output logic                 load_error_o
);

    localparam int DW     = NCOL * 8;
    localparam int LANE_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NCOL - 1);

    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic [15:0]         idx_q;
    logic [LANE_W-1:0]   lane_q;
    logic [7:0]          chk_q;
    logic [DW-9:0]       shift_q;

    logic                accept_d;
    logic [15:0]         cnt_d;
    logic [15:0]         idx_d;
    logic [AW-1:0]       addr_d;
    logic                cnt_bad_d;

    assign accept_d  = s_valid_i & s_ready_o;
    assign cnt_d     = {s_data_i, cnt_q[7:0]};
    assign idx_d     = idx_q + 16'd1;
    assign addr_d    = AW'(BASE_WORD) + idx_q[AW-1:0];
    assign cnt_bad_d = (cnt_d == 16'd0) || (cnt_d > 16'(MEM_WORDS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HDR_LO;
            cnt_q        <= '0;
            idx_q        <= '0;
            lane_q       <= '0;
            chk_q        <= '0;
            shift_q      <= '0;
            s_ready_o    <= 1'b0;
            mem_we_o     <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            core_reset_o <= 1'b1;
            load_done_o  <= 1'b0;
            load_error_o <= 1'b0;
        end else begin
            s_ready_o <= 1'b1;
            mem_we_o  <= '0;
            case (state_q)
                S_HDR_LO: begin
                    if (accept_d) begin
                        cnt_q[7:0] <= s_data_i;
                        state_q    <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (accept_d) begin
                        cnt_q[15:8] <= s_data_i;
                        idx_q       <= '0;
                        lane_q      <= '0;
                        chk_q       <= '0;
                        if (cnt_bad_d) begin
                            load_error_o <= 1'b1;
                            state_q      <= S_ERR;
                        end else begin
                            state_q      <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_d) begin
                        chk_q   <= chk_q ^ s_data_i;
                        lane_q  <= lane_q + 1'b1;
                        // Lower lanes accumulate right-shifted so b0 ends up in the LSBs.
                        shift_q <= {s_data_i, shift_q[DW-9:8]};
                        if (lane_q == LAST_LANE) begin
                            mem_we_o    <= '1;
                            mem_addr_o  <= addr_d;
                            mem_wdata_o <= {s_data_i, shift_q};
                            idx_q       <= idx_d;
                            if (idx_d == cnt_q) begin
                                state_q <= S_CHK;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (accept_d) begin
                        if (s_data_i == chk_q) begin
                            core_reset_o <= 1'b0;
                            load_done_o  <= 1'b1;
                            state_q      <= S_RUN;
                        end else begin
                            load_error_o <= 1'b1;
                            state_q      <= S_ERR;
                        end
                    end
                end
                S_RUN: begin
                    if (accept_d) begin
                        cnt_q[7:0]   <= s_data_i;
                        core_reset_o <= 1'b1;
                        load_done_o  <= 1'b0;
                        state_q      <= S_HDR_HI;
                    end
                end
                S_ERR: begin
                    if (accept_d) begin
                        cnt_q[7:0]   <= s_data_i;
                        load_error_o <= 1'b0;
                        state_q      <= S_HDR_HI;
                    end
                end
                default: begin
                    state_q <= S_HDR_LO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream loader that writes a program image into the core's instruction/data BRAM and holds the hart threads in reset until the image is complete and verified. It sits between a host byte link (UART RX or JTAG bridge) and the BRAM write port, on the opposite side from the core's fetch read port. Each 32-bit word is assembled little-endian and written with all four byte lanes enabled. The image is checked against a trailing XOR checksum before the core is released.

## Interface
Parameters:
- MEM_WORDS, default MEMORY_SIZE (1024): maximum accepted word count.
- AW, default ADDR_WIDTH (10): BRAM word-address width.
- NCOL, default NB_COL (4): byte lanes per word. COL_WIDTH is 8, so the data width is NCOL*8 = 32.
- BASE_WORD, default STARTUP_ADDR >> 2 (0): word address of the first written word.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- s_valid, in, 1: input byte valid.
- s_data, in, 8: input byte.
- s_ready, out, 1: loader can accept a byte.
- mem_we, out, NCOL: byte-lane write enables.
- mem_addr, out, AW: BRAM word address.
- mem_wdata, out, 32: BRAM write data.
- core_reset, out, 1: holds the core/threads in reset.
- load_done, out, 1: image loaded and checksum matched.
- load_error, out, 1: bad count or checksum mismatch.

## Operation
Frame format:
- CNT_LO byte, then CNT_HI byte: the word count N.
- 4N data bytes.
- One CHK byte, equal to the XOR of all 4N data bytes. Header bytes are not included in the checksum.

A byte is accepted on any cycle with s_valid && s_ready.

States:
- HDR_LO: accept a byte and store it as cnt[7:0]. Next state is HDR_HI.
- HDR_HI: accept a byte and store it as cnt[15:8].
  - If the full count is 0 or greater than MEM_WORDS, go to ERR.
  - Otherwise go to DATA. Clear the word index, lane counter and checksum.
- DATA: each accepted byte goes into lane[1:0] of the word shift register and is XORed into the checksum.
  - On the lane-3 byte, issue a registered write: mem_we = all ones, mem_addr = BASE_WORD + idx (mod 2^AW), mem_wdata = {b3,b2,b1,b0}. Then increment idx.
  - When idx reaches N on this byte, go to CHK.
- CHK: accept one byte. If it equals the checksum, go to RUN; otherwise go to ERR.
- RUN: core_reset = 0 and load_done = 1. An accepted byte restarts a load:
  - the byte is taken as CNT_LO;
  - core_reset = 1 and load_done = 0 from the next cycle;
  - next state is HDR_HI.
- ERR: core_reset = 1 and load_error = 1. An accepted byte is taken as CNT_LO. load_error clears and the next state is HDR_HI.

Other rules:
- s_ready is 1 in every state after reset. No backpressure is needed because the BRAM write is a single cycle.
- mem_we is 0 in every cycle except write pulses.
- mem_addr and mem_wdata hold their last value between writes.
- Reset mid-load returns to HDR_LO. Words already written stay in BRAM, core_reset reasserts, and both flags clear.
- Address wrap: BASE_WORD + idx wraps modulo 2^AW. No error is raised, since N ≤ MEM_WORDS is the only check.

## Timing
- Reset values, all registered: s_ready = 0 during the reset cycle and 1 from the first cycle after reset deasserts. core_reset = 1. load_done = 0. load_error = 0. mem_we = 0. mem_addr = 0. mem_wdata = 0.
- Write latency: mem_we pulses for exactly 1 cycle, in the cycle after the lane-3 byte is accepted.
- Release latency: core_reset falls and load_done rises in the cycle after the matching CHK byte is accepted.
- Error latency: load_error rises in the cycle after the offending CNT_HI or CHK byte is accepted.
- Back-to-back bytes (s_valid held high) are accepted every cycle. This gives one write every 4 cycles, and consecutive write pulses are separated by at least 3 idle cycles.
- s_valid low mid-word stalls the lane counter and checksum. State is kept indefinitely, with no timeout.
- reset asserted in the same cycle as an accepted byte: reset wins and the byte is dropped.

## Test plan
- **Minimal load:** input 01 00, AA BB CC DD, CHK = AA^BB^CC^DD = 0x00.
  - One write pulse: addr 0, wdata 0xDDCCBBAA, we = 4'hF.
  - Then core_reset = 0 and load_done = 1, one cycle after the CHK byte.
- **Full load:** N = 1024 (00 04), data byte i = i mod 256, correct CHK.
  - 1024 writes, at addresses 0..1023, in order.
  - load_done = 1, load_error = 0.
- **Count errors:**
  - Header 00 00 → load_error = 1, no writes, core_reset = 1.
  - Header 01 04 (N = 1025) → load_error = 1, no writes.
- **Checksum mismatch:** N = 2, data 11 22 33 44 55 66 77 88, CHK = 0xFF (correct is 0x88).
  - Two writes occur: 0x44332211 at addr 0 and 0x88776655 at addr 1.
  - Then load_error = 1 and core_reset stays 1.
- **Reload from RUN and gapped input:** after a successful load, send a new frame with N = 1 and random s_valid gaps.
  - core_reset reasserts one cycle after CNT_LO and load_done = 0.
  - The new word is written correctly despite the gaps, and the core is released after CHK.
- **Mid-load reset:** pulse reset after 6 data bytes of an N = 4 frame.
  - One write occurred (addr 0) and no further writes follow.
  - All outputs return to reset values.
  - A fresh frame then loads successfully.
